// File: rtl/csc_stream_ctrl.sv
// Stream controller around a fixed-latency YUV-to-RGB converter: delays the source
// stream to match the converter, switches output mode on frame boundaries and tracks frame geometry.
module csc_stream_ctrl #(
  parameter int LAT = 4,
  parameter int CW  = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_en,
  input  logic [1:0]    cfg_mode,
  input  logic [7:0]    y_in,
  input  logic [7:0]    u_in,
  input  logic [7:0]    v_in,
  input  logic          vs_in,
  input  logic          hs_in,
  input  logic          de_in,
  output logic [7:0]    csc_y,
  output logic [7:0]    csc_u,
  output logic [7:0]    csc_v,
  output logic          csc_vs,
  output logic          csc_hs,
  output logic          csc_de,
  input  logic [7:0]    csc_r,
  input  logic [7:0]    csc_g,
  input  logic [7:0]    csc_b,
  output logic [7:0]    r_out,
  output logic [7:0]    g_out,
  output logic [7:0]    b_out,
  output logic          vs_out,
  output logic          hs_out,
  output logic          de_out,
  output logic [1:0]    act_mode,
  output logic [CW-1:0] frame_width,
  output logic [CW-1:0] frame_height,
  output logic          line_err,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam int DW = 27;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t               state;
  state_t               state_nxt;
  logic                 load_stats;
  logic                 mode_latch;
  logic [1:0]           mode_sel;
  logic [1:0]           in_mode;

  logic                 vs_prev;
  logic                 de_prev;
  logic                 vs_rise;
  logic                 de_rise;
  logic                 de_fall;

  logic [LAT-1:0][DW-1:0] pix_d;
  logic [LAT-1:0][1:0]    mode_d;
  logic [DW-1:0]          pix_o;
  logic [7:0]             y_o;
  logic [7:0]             u_o;
  logic [7:0]             v_o;

  logic [CW-1:0]        pix_cnt;
  logic [CW-1:0]        line_cnt;
  logic [CW-1:0]        ref_w;
  logic                 ref_valid;
  logic [CW-1:0]        line_cnt_inc;
  logic [CW-1:0]        close_height;
  logic [CW-1:0]        close_width;

  // Converter input is a straight wire; the converter owns its own pipeline.
  assign csc_y  = y_in;
  assign csc_u  = u_in;
  assign csc_v  = v_in;
  assign csc_vs = vs_in;
  assign csc_hs = hs_in;
  assign csc_de = de_in;

  assign vs_rise = vs_in & ~vs_prev;
  assign de_rise = de_in & ~de_prev;
  assign de_fall = ~de_in & de_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev <= 1'b0;
      de_prev <= 1'b0;
    end else begin
      vs_prev <= vs_in;
      de_prev <= de_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_stats = 1'b0;
    mode_latch = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_en) state_nxt = WAIT_VS;
      end
      WAIT_VS: begin
        // The frame in flight when we arrive is partial, so no stats here.
        if (vs_rise) begin
          state_nxt  = ACTIVE;
          mode_latch = 1'b1;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          load_stats = 1'b1;
          if (cfg_en) mode_latch = 1'b1;
          else        state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mode_sel = (cfg_mode == 2'b11) ? 2'b00 : cfg_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_mode <= 2'b00;
    end else if (mode_latch) begin
      in_mode <= mode_sel;
    end else if (state_nxt != ACTIVE) begin
      in_mode <= 2'b00;
    end
  end

  // in_mode already lags the vs edge by one register, so after LAT more stages
  // it lines up with the first delayed pixel following the delayed vs edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_d  <= '0;
      mode_d <= '0;
    end else begin
      pix_d[0]  <= {vs_in, hs_in, de_in, y_in, u_in, v_in};
      mode_d[0] <= in_mode;
      for (int i = LAT - 1; i > 0; i--) begin
        pix_d[i]  <= pix_d[i-1];
        mode_d[i] <= mode_d[i-1];
      end
    end
  end

  assign pix_o    = pix_d[LAT-1];
  assign vs_out   = pix_o[26];
  assign hs_out   = pix_o[25];
  assign de_out   = pix_o[24];
  assign y_o      = pix_o[23:16];
  assign u_o      = pix_o[15:8];
  assign v_o      = pix_o[7:0];
  assign act_mode = mode_d[LAT-1];

  always_comb begin
    r_out = y_o;
    g_out = u_o;
    b_out = v_o;
    case (act_mode)
      2'b01: begin
        r_out = csc_r;
        g_out = csc_g;
        b_out = csc_b;
      end
      2'b10: begin
        r_out = y_o;
        g_out = y_o;
        b_out = y_o;
      end
      default: begin
        r_out = y_o;
        g_out = u_o;
        b_out = v_o;
      end
    endcase
  end

  // A line ending in the same cycle as the closing vs edge still belongs to the closing frame.
  assign line_cnt_inc = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + CNT_ONE;
  assign close_height = de_fall ? line_cnt_inc : line_cnt;
  assign close_width  = (de_fall && !ref_valid) ? pix_cnt : ref_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
    end else if (state != IDLE) begin
      if (de_rise) begin
        pix_cnt <= CNT_ONE;
      end else if (de_in && pix_cnt != CNT_MAX) begin
        pix_cnt <= pix_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt     <= '0;
      ref_w        <= '0;
      ref_valid    <= 1'b0;
      line_err     <= 1'b0;
      frame_width  <= '0;
      frame_height <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == ACTIVE) begin
        if (load_stats) begin
          frame_width  <= close_width;
          frame_height <= close_height;
          frame_done   <= 1'b1;
          line_cnt     <= '0;
          ref_w        <= '0;
          ref_valid    <= 1'b0;
          line_err     <= 1'b0;
        end else if (de_fall) begin
          line_cnt <= line_cnt_inc;
          if (!ref_valid) begin
            ref_w     <= pix_cnt;
            ref_valid <= 1'b1;
          end else if (pix_cnt != ref_w) begin
            line_err <= 1'b1;
          end
        end
      end else if (state == WAIT_VS && vs_rise) begin
        line_cnt  <= '0;
        ref_w     <= '0;
        ref_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csc_stream_ctrl.sv
// Directed bench for csc_stream_ctrl with a fixed-latency converter model
// (r = ~y, g = u ^ 0x5A, b = v + 3) driven from the csc_* taps.
module tb_csc_stream_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_en;
  logic [1:0]    cfg_mode;
  logic [7:0]    y_in, u_in, v_in;
  logic          vs_in, hs_in, de_in;
  logic [7:0]    csc_y, csc_u, csc_v;
  logic          csc_vs, csc_hs, csc_de;
  logic [7:0]    csc_r, csc_g, csc_b;
  logic [7:0]    r_out, g_out, b_out;
  logic          vs_out, hs_out, de_out;
  logic [1:0]    act_mode;
  logic [CW-1:0] frame_width, frame_height;
  logic          line_err, frame_done;

  int n_asserts = 0;
  int n_fail    = 0;
  int fd_count  = 0;
  int fd_snap;

  logic       fd_rise, err_rise, err_before;
  logic [1:0] mode_tr [6];
  logic       vs_tr   [6];

  always #5 clk = ~clk;

  csc_stream_ctrl #(.LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .y_in(y_in), .u_in(u_in), .v_in(v_in),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .csc_y(csc_y), .csc_u(csc_u), .csc_v(csc_v),
    .csc_vs(csc_vs), .csc_hs(csc_hs), .csc_de(csc_de),
    .csc_r(csc_r), .csc_g(csc_g), .csc_b(csc_b),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .act_mode(act_mode), .frame_width(frame_width), .frame_height(frame_height),
    .line_err(line_err), .frame_done(frame_done)
  );

  logic [7:0] mr [LAT];
  logic [7:0] mg [LAT];
  logic [7:0] mb [LAT];

  always @(posedge clk) begin
    mr[0] <= ~csc_y;
    mg[0] <= csc_u ^ 8'h5A;
    mb[0] <= csc_v + 8'h03;
    for (int i = 1; i < LAT; i++) begin
      mr[i] <= mr[i-1];
      mg[i] <= mg[i-1];
      mb[i] <= mb[i-1];
    end
  end

  assign csc_r = mr[LAT-1];
  assign csc_g = mg[LAT-1];
  assign csc_b = mb[LAT-1];

  always @(negedge clk) begin
    if (frame_done) fd_count <= fd_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic vs, input logic hs, input logic de,
                     input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    vs_in = vs;
    hs_in = hs;
    de_in = de;
    y_in  = y;
    u_in  = u;
    v_in  = v;
    @(negedge clk);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic vs_pulse();
    err_before = line_err;
    for (int i = 0; i < 6; i++) begin
      cyc(i < 2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      if (i == 0) begin
        fd_rise  = frame_done;
        err_rise = line_err;
      end
      mode_tr[i] = act_mode;
      vs_tr[i]   = vs_out;
    end
  endtask

  task automatic send_line(input int px, input int trail);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    blank(1);
    for (int p = 0; p < px; p++) cyc(1'b0, 1'b0, 1'b1, 8'(p), 8'(p + 1), 8'(p + 2));
    blank(trail);
  endtask

  task automatic send_frame(input int lines, input int short_line);
    vs_pulse();
    for (int l = 0; l < lines; l++) send_line((l == short_line) ? 7 : 8, 2);
  endtask

  task automatic probe(input string tag, input logic [1:0] em,
                       input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    cyc(1'b0, 1'b0, 1'b0, 8'h10, 8'h20, 8'h30);
    blank(3);
    chk({tag, "_mode"}, 32'(act_mode), 32'(em));
    chk({tag, "_r"}, 32'(r_out), 32'(er));
    chk({tag, "_g"}, 32'(g_out), 32'(eg));
    chk({tag, "_b"}, 32'(b_out), 32'(eb));
  endtask

  initial begin
    rst_n    = 1'b0;
    cfg_en   = 1'b0;
    cfg_mode = 2'b00;
    y_in = 8'h11; u_in = 8'h22; v_in = 8'h33;
    vs_in = 1'b1; hs_in = 1'b1; de_in = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state and converter pass-through
    chk("rst_r", 32'(r_out), 32'h0);
    chk("rst_g", 32'(g_out), 32'h0);
    chk("rst_b", 32'(b_out), 32'h0);
    chk("rst_syncs", 32'({vs_out, hs_out, de_out}), 32'h0);
    chk("rst_mode", 32'(act_mode), 32'h0);
    chk("rst_stats", 32'({frame_width, frame_height, line_err, frame_done}), 32'h0);
    chk("pass_y", 32'(csc_y), 32'h11);
    chk("pass_syncs", 32'({csc_vs, csc_hs, csc_de}), 32'h7);

    rst_n = 1'b1;
    blank(2);

    // Bypass latency: pixel appears exactly LAT cycles later
    cyc(1'b1, 1'b1, 1'b1, 8'h10, 8'h20, 8'h30);
    blank(2);
    chk("lat_early_r", 32'(r_out), 32'h0);
    chk("lat_early_vs", 32'(vs_out), 32'h0);
    blank(1);
    chk("lat_r", 32'(r_out), 32'h10);
    chk("lat_g", 32'(g_out), 32'h20);
    chk("lat_b", 32'(b_out), 32'h30);
    chk("lat_syncs", 32'({vs_out, hs_out, de_out}), 32'h7);
    blank(2);

    // Three 4x8 frames in yuv2rgb mode
    cfg_en   = 1'b1;
    cfg_mode = 2'b01;
    blank(1);
    send_frame(4, -1);
    chk("entry_no_fd", 32'(fd_rise), 32'h0);
    send_frame(4, -1);
    send_frame(4, -1);
    blank(2);
    chk("fd_count_3f", 32'(fd_count), 32'd2);
    chk("width_3f", 32'(frame_width), 32'd8);
    chk("height_3f", 32'(frame_height), 32'd4);
    chk("err_3f", 32'(line_err), 32'h0);
    probe("csc", 2'b01, 8'hEF, 8'h7A, 8'h33);

    // Short third line raises line_err until the closing vs edge
    send_frame(4, 2);
    chk("short_err", 32'(line_err), 32'h1);
    vs_pulse();
    chk("short_err_before", 32'(err_before), 32'h1);
    chk("short_fd", 32'(fd_rise), 32'h1);
    chk("short_err_clr", 32'(err_rise), 32'h0);
    chk("short_width", 32'(frame_width), 32'd8);
    chk("short_height", 32'(frame_height), 32'd4);

    // Mode change mid-frame waits for the next frame boundary
    send_line(8, 2);
    send_line(8, 2);
    cfg_mode = 2'b10;
    probe("mid_sw", 2'b01, 8'hEF, 8'h7A, 8'h33);
    send_frame(4, -1);
    chk("sw_vs_before", 32'(vs_tr[2]), 32'h0);
    chk("sw_vs_at", 32'(vs_tr[3]), 32'h1);
    chk("sw_mode_hold", 32'(mode_tr[3]), 32'h1);
    chk("sw_mode_new", 32'(mode_tr[4]), 32'h2);
    chk("sw_height", 32'(frame_height), 32'd2);
    probe("grey", 2'b10, 8'h10, 8'h10, 8'h10);

    // Disable during ACTIVE: old mode until the next vs edge, then idle
    cfg_en = 1'b0;
    probe("dis_hold", 2'b10, 8'h10, 8'h10, 8'h10);
    send_frame(4, -1);
    chk("dis_fd", 32'(fd_rise), 32'h1);
    chk("dis_mode_hold", 32'(mode_tr[3]), 32'h2);
    chk("dis_mode_off", 32'(mode_tr[4]), 32'h0);
    fd_snap = fd_count;
    send_frame(4, 2);
    blank(2);
    chk("idle_no_fd", 32'(fd_count), 32'(fd_snap));
    chk("idle_width", 32'(frame_width), 32'd8);
    chk("idle_height", 32'(frame_height), 32'd4);
    chk("idle_err", 32'(line_err), 32'h0);
    probe("bypass", 2'b00, 8'h10, 8'h20, 8'h30);

    // Reset mid-line
    cfg_en   = 1'b1;
    cfg_mode = 2'b01;
    blank(1);
    vs_pulse();
    send_line(8, 2);
    send_line(8, 2);
    vs_pulse();
    chk("pre_rst_fd", 32'(fd_rise), 32'h1);
    chk("pre_rst_height", 32'(frame_height), 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    blank(1);
    for (int p = 0; p < 6; p++) cyc(1'b0, 1'b0, 1'b1, 8'h80, 8'h01, 8'h02);
    chk("pre_rst_r", 32'(r_out), 32'h7F);
    chk("pre_rst_de", 32'(de_out), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", 32'({r_out, g_out, b_out}), 32'h0);
    chk("mid_rst_syncs", 32'({vs_out, hs_out, de_out}), 32'h0);
    chk("mid_rst_mode", 32'(act_mode), 32'h0);
    chk("mid_rst_stats", 32'({frame_width, frame_height, line_err, frame_done}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    blank(2);
    vs_pulse();
    chk("post_rst_no_fd", 32'(fd_rise), 32'h0);
    blank(2);
    fd_snap = fd_count;

    // Last line ends in the same cycle as the closing vs edge
    send_line(8, 2);
    send_line(8, 2);
    send_line(8, 0);
    vs_pulse();
    chk("coinc_fd", 32'(fd_rise), 32'h1);
    chk("coinc_width", 32'(frame_width), 32'd8);
    chk("coinc_height", 32'(frame_height), 32'd3);
    chk("coinc_err", 32'(line_err), 32'h0);
    blank(2);
    chk("coinc_fd_count", 32'(fd_count), 32'(fd_snap + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
